clk_enable_ctrl: RTL and testbench

//  Consumes the 32 ripple-divided taps from the T-FF divider and produces a

---
 rtl/clk_ctrl_pkg.sv | 13 +
 rtl/btn_debounce.sv | 45 ++++
 rtl/clk_enable_ctrl.sv | 113 +++++++++++
 tb/tb_clk_enable_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared encodings and constants for the clock-enable controller.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_STEP_ARM = 2'b10
    } ctrl_state_e;

    localparam int BLANK_CYCLES = 3;
    localparam int BLANK_W      = $clog2(BLANK_CYCLES + 1);

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw board button, debounces it, and emits a one-cycle pulse
// on each accepted press.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, press_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/clk_enable_ctrl.sv
// Turns a selected divider tap into a glitch-free one-cycle core enable,
// gated by a RUN / HALT / single-step controller.
module clk_enable_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int TAP_W     = 32,
    parameter int SEL_W     = 5,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAP_W-1:0] div_taps,
    input  logic [SEL_W-1:0] tap_sel,
    input  logic             mode_run,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] tick_count,
    output logic [1:0]       ctrl_state
);

    logic               s1_q, s2_q, s3_q;
    logic [SEL_W-1:0]   tap_sel_q;
    logic [BLANK_W-1:0] blank_q;
    logic               tick;
    logic               step_req;
    ctrl_state_e        state_q, state_d;
    logic               ce_q, ce_d;
    logic [CNT_W-1:0]   tick_q;

    // s1 is the metastability catcher; edge detection uses only s2/s3.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            tap_sel_q <= '0;
            blank_q   <= '0;
        end else begin
            s1_q      <= div_taps[tap_sel];
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            tap_sel_q <= tap_sel;
            if (tap_sel != tap_sel_q)
                blank_q <= BLANK_W'(BLANK_CYCLES);
            else if (blank_q != '0)
                blank_q <= blank_q - 1'b1;
        end
    end

    // Blanking hides the false edge a tap switch can inject into the pipe.
    assign tick = s2_q & ~s3_q & (blank_q == '0);

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_step_db (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (step_btn),
        .press_o(step_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
            ce_q    <= 1'b0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
            tick_q  <= tick_q + CNT_W'(ce_q);
        end
    end

    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (halt_req || !mode_run)
                    state_d = ST_HALT;
                else
                    ce_d = tick;
            end
            ST_STEP_ARM: begin
                if (halt_req)
                    state_d = ST_HALT;
                else if (mode_run)
                    state_d = ST_RUN;
                else if (tick) begin
                    ce_d    = 1'b1;
                    state_d = ST_HALT;
                end
            end
            default: begin
                // Covers the unused 2'b11 encoding as well as HALT.
                state_d = ST_HALT;
                if (halt_req)
                    state_d = ST_HALT;
                else if (mode_run)
                    state_d = ST_RUN;
                else if (step_req)
                    state_d = ST_STEP_ARM;
            end
        endcase
    end

    assign cpu_ce     = ce_q;
    assign tick_count = tick_q;
    assign ctrl_state = state_q;

endmodule

// File: tb/tb_clk_enable_ctrl.sv
// Directed bench for clk_enable_ctrl driven by a model ripple divider.
module tb_clk_enable_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] div_cnt = '0;
    logic [4:0]  tap_sel = '0;
    logic        mode_run = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt_req = 1'b0;
    logic        cpu_ce;
    logic [15:0] tick_count;
    logic [1:0]  ctrl_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] sel;
        logic       run;
        logic       hlt;
        logic [1:0] exp_st;
        int         exp_pulses;
    } vec_t;
    vec_t vecs[7];

    clk_enable_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .div_taps  (div_cnt),
        .tap_sel   (tap_sel),
        .mode_run  (mode_run),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .cpu_ce    (cpu_ce),
        .tick_count(tick_count),
        .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    // Divider model: bit k of div_cnt is Qt[k]; it changes mid-cycle.
    always @(posedge clk) begin
        #3;
        div_cnt = div_cnt + 32'd1;
    end

    logic ce_prev = 1'b0;
    bit   consec  = 1'b0;
    always @(negedge clk) begin
        if (!rst && cpu_ce && ce_prev) consec = 1'b1;
        ce_prev = rst ? 1'b0 : cpu_ce;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Returns at the negedge just after posedge N-1, where Qt[b] rose between N-1 and N.
    task automatic wait_tap_rise(input int b, output bit ok);
        logic [31:0] mask, want;
        int w;
        mask = (32'd1 << (b + 1)) - 32'd1;
        want = 32'd1 << b;
        w = 0;
        do begin
            @(posedge clk); #4; w++;
        end while (((div_cnt & mask) != want) && w < 600);
        ok = ((div_cnt & mask) == want);
        @(negedge clk);
    endtask

    task automatic wait_ce(output bit ok);
        int w;
        w = 0;
        while (!cpu_ce && w < 40) begin
            @(negedge clk); w++;
        end
        ok = cpu_ce;
    endtask

    initial begin
        int n, arm, tc0;
        bit ok;
        logic c1, c2, c3;

        vecs[0] = '{5'd0, 1'b1, 1'b0, 2'b01, 12};
        vecs[1] = '{5'd1, 1'b1, 1'b0, 2'b01, 6};
        vecs[2] = '{5'd2, 1'b1, 1'b0, 2'b01, 3};
        vecs[3] = '{5'd0, 1'b0, 1'b0, 2'b00, 0};
        vecs[4] = '{5'd0, 1'b1, 1'b1, 2'b00, 0};
        vecs[5] = '{5'd0, 1'b1, 1'b0, 2'b01, 12};
        vecs[6] = '{5'd1, 1'b0, 1'b1, 2'b00, 0};

        // Reset held with taps toggling and RUN requested
        mode_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ce", 32'(cpu_ce), 32'd0);
            check("rst_count", 32'(tick_count), 32'd0);
            check("rst_state", 32'(ctrl_state), 32'd0);
        end
        rst = 1'b0;

        // Tap 0: one enable every 2 cycles, 50 in 100 cycles
        wait_ce(ok);
        check("t2_first_ce", 32'(ok), 32'd1);
        check("t2_count_at_first", 32'(tick_count), 32'd0);
        repeat (100) @(negedge clk);
        check("t2_count_100", 32'(tick_count), 32'd50);

        for (int v = 0; v < 7; v++) begin
            tap_sel  = vecs[v].sel;
            mode_run = vecs[v].run;
            halt_req = vecs[v].hlt;
            repeat (6) @(negedge clk);
            tc0 = int'(tick_count);
            n = 0;
            repeat (24) begin
                n += int'(cpu_ce);
                @(negedge clk);
            end
            check("vec_state", 32'(ctrl_state), 32'(vecs[v].exp_st));
            check("vec_pulses", 32'(n), 32'(vecs[v].exp_pulses));
            check("vec_count_delta", 32'((int'(tick_count) - tc0) & 16'hFFFF), 32'(vecs[v].exp_pulses));
        end
        halt_req = 1'b0;

        // Tap 3: latency of 3 edges from the tap rise, then 16-cycle period
        tap_sel = 5'd3;
        mode_run = 1'b1;
        repeat (8) @(negedge clk);
        wait_tap_rise(3, ok);
        check("t3_tap_rise_seen", 32'(ok), 32'd1);
        @(negedge clk); c1 = cpu_ce;
        @(negedge clk); c2 = cpu_ce;
        @(negedge clk); c3 = cpu_ce;
        check("t3_latency", 32'({c1, c2, c3}), 32'b001);
        n = 0;
        repeat (15) begin
            @(negedge clk); n += int'(cpu_ce);
        end
        check("t3_gap", 32'(n), 32'd0);
        @(negedge clk);
        check("t3_period", 32'(cpu_ce), 32'd1);

        // halt_req in the very cycle the tick is live
        wait_tap_rise(3, ok);
        @(negedge clk);
        @(negedge clk);
        tc0 = int'(tick_count);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("t5_no_ce", 32'(cpu_ce), 32'd0);
        check("t5_state_halt", 32'(ctrl_state), 32'd0);
        @(negedge clk);
        check("t5_count_held", 32'(tick_count), 32'(tc0));

        // Single step: bouncing press, long hold, then release
        mode_run = 1'b0;
        tap_sel = 5'd2;
        repeat (8) @(negedge clk);
        arm = 0;
        for (int i = 0; i < 5; i++) begin
            step_btn = 1'b1;
            repeat (3) begin
                @(negedge clk); if (ctrl_state == 2'b10) arm = 1;
            end
            step_btn = 1'b0;
            repeat (3) begin
                @(negedge clk); if (ctrl_state == 2'b10) arm = 1;
            end
        end
        check("t4_bounce_no_arm", 32'(arm), 32'd0);
        step_btn = 1'b1;
        n = 0;
        repeat (60) begin
            @(negedge clk);
            n += int'(cpu_ce);
            if (ctrl_state == 2'b10) arm = 1;
        end
        check("t4_step_pulses", 32'(n), 32'd1);
        check("t4_saw_arm", 32'(arm), 32'd1);
        check("t4_back_halt", 32'(ctrl_state), 32'd0);
        step_btn = 1'b0;
        n = 0;
        repeat (30) begin
            @(negedge clk); n += int'(cpu_ce);
        end
        check("t4_release_pulses", 32'(n), 32'd0);

        // halt_req while armed cancels the step
        tap_sel = 5'd3;
        repeat (6) @(negedge clk);
        step_btn = 1'b1;
        n = 0;
        while (ctrl_state != 2'b10 && n < 40) begin
            @(negedge clk); n++;
        end
        check("t4b_armed", 32'(ctrl_state), 32'd2);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("t4b_state_halt", 32'(ctrl_state), 32'd0);
        n = int'(cpu_ce);
        repeat (20) begin
            @(negedge clk); n += int'(cpu_ce);
        end
        check("t4b_no_pulse", 32'(n), 32'd0);
        step_btn = 1'b0;
        repeat (25) @(negedge clk);

        // Tap switch 2 -> 7 at a point where the raw mux output jumps 0 -> 1
        tap_sel = 5'd2;
        mode_run = 1'b1;
        repeat (8) @(negedge clk);
        n = 0;
        do begin
            @(posedge clk); #4; n++;
        end while (!(div_cnt[7] && div_cnt[2:0] == 3'd2) && n < 400);
        check("t6_align", 32'(div_cnt[7] && div_cnt[2:0] == 3'd2), 32'd1);
        tap_sel = 5'd7;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        repeat (3) begin
            @(negedge clk); n += int'(cpu_ce);
        end
        check("t6_blanked", 32'(n), 32'd0);

        // Counter wrap from all-ones
        mode_run = 1'b0;
        repeat (4) @(negedge clk);
        force dut.tick_q = 16'hFFFF;
        @(negedge clk);
        release dut.tick_q;
        @(negedge clk);
        check("t6_preload", 32'(tick_count), 32'hFFFF);
        tap_sel = 5'd0;
        mode_run = 1'b1;
        repeat (6) @(negedge clk);
        wait_ce(ok);
        check("t6_pulse", 32'(ok), 32'd1);
        check("t6_before_wrap", 32'(tick_count), 32'hFFFF);
        @(negedge clk);
        check("t6_wrap", 32'(tick_count), 32'd0);

        // Reset during a live pulse
        wait_ce(ok);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ce", 32'(cpu_ce), 32'd0);
        check("rst_mid_count", 32'(tick_count), 32'd0);
        check("rst_mid_state", 32'(ctrl_state), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("no_back_to_back", 32'(consec), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
